boot_copier: RTL
================

// Module: boot_copier
// PURPOSE
//   Boot sequencer: after reset, copies the boot image out of the 256-byte boot ROM into main RAM,
//   one 16-bit little-endian word at a time, then releases the CPU from reset. Initiator side of the
//   boot ROM read port (enable/addr in, registered 16-bit data out, 1-cycle latency) and master of
//   the RAM write port. Sits between bootrom, RAM and the CPU reset input in the top level.
// PARAMETERS
//   ROM_BYTES   256      image size in bytes; even, 2..256; words copied = ROM_BYTES/2
//   DEST_BASE   16'h0000 RAM byte address receiving ROM byte 0; must be even
//   AUTO_START  1        1: copy starts on first cycle after reset; 0: waits for I_start
// PORTS
//   I_clk         in   1   clock; all logic on posedge
//   I_reset       in   1   synchronous, active-high reset
//   I_start       in   1   1-cycle pulse: (re)start copy; honoured only in IDLE or DONE
//   O_rom_enable  out  1   ROM read strobe
//   O_rom_addr    out  8   ROM byte address (always even)
//   I_rom_data    in   16  ROM data, valid the cycle after O_rom_enable sampled high
//   O_ram_we      out  1   RAM write request, held until accepted
//   O_ram_addr    out  16  RAM byte address of current word
//   O_ram_data    out  16  word to write
//   I_ram_ready   in   1   RAM accepts write when O_ram_we && I_ram_ready at a posedge
//   O_busy        out  1   copy in progress
//   O_done        out  1   copy complete (sticky until next start or reset)
//   O_cpu_reset   out  1   CPU reset; high until first copy completes
// BEHAVIOUR
//   Reset: state=AUTO_START?READ:IDLE; idx=0; O_rom_enable=0, O_rom_addr=0, O_ram_we=0,
//     O_ram_addr=DEST_BASE, O_ram_data=0, O_done=0, O_cpu_reset=1; O_busy=AUTO_START. All regs.
//   States IDLE, READ, LATCH, WRITE, DONE:
//   - IDLE: outputs quiet; I_start -> READ, idx=0, O_busy=1.
//   - READ: O_rom_enable=1, O_rom_addr={idx,1'b0} for one cycle -> LATCH.
//   - LATCH: O_rom_enable=0; O_ram_data<=I_rom_data, O_ram_addr<=DEST_BASE+{idx,1'b0},
//     O_ram_we<=1 -> WRITE.
//   - WRITE: hold we/addr/data stable until I_ram_ready at posedge. On accept: we<=0; if
//     idx==ROM_BYTES/2-1 -> DONE (O_done<=1, O_busy<=0, O_cpu_reset<=0) else idx++ -> READ.
//   - DONE: idle; O_cpu_reset stays 0; I_start -> READ, idx=0, O_done<=0, O_busy<=1
//     (CPU is not re-held in reset on restart).
//   Latency: 3 cycles per word with I_ram_ready tied 1; full 256-byte image = 384 cycles
//     from reset release to O_done.
//   Arithmetic: idx is 7 bits; RAM address add is 16-bit, wraps modulo 2^16 (no error).
//   Byte order: RAM word = {ROM[2i+1], ROM[2i]} exactly as delivered on I_rom_data.
//   I_start outside IDLE/DONE ignored; I_start same cycle as I_reset ignored (reset wins).
//   Reset mid-copy: abort immediately, return to reset state, O_cpu_reset=1, copy restarts from
//     byte 0 (AUTO_START=1); partial RAM contents are overwritten.
//   ROM is never addressed at odd addresses, so its addr+1 wrap at 255 is not exercised.
// TESTING
//   1 AUTO_START=1, ROM bytes = index, I_ram_ready=1 -> 128 writes, word i = {2i+1,2i},
//     addr 0..254 step 2; O_done and O_cpu_reset=0 at cycle 384 after reset release.
//   2 I_ram_ready random 30% -> we/addr/data stable while stalled; same 128 writes, no dup/skip.
//   3 DEST_BASE=16'hFFF0, ROM_BYTES=32 -> addrs FFF0..FFFE then 0000..000E (wrap); 16 writes.
//   4 Reset asserted at word 50 -> O_cpu_reset=1, all outputs reset values next cycle; full copy
//     reruns from ROM addr 0.
//   5 AUTO_START=0 -> no ROM/RAM activity until I_start; I_start during WRITE ignored; I_start
//     in DONE -> O_done=0, copy repeats, O_cpu_reset stays 0.
//   6 Check ROM handshake: every O_rom_enable is a 1-cycle pulse, captured data equals ROM model
//     output one cycle later; O_rom_addr LSB always 0.

Source files
------------

// File: rtl/boot_copier_if.sv
// Boot copier bus bundle: ROM read port, RAM write port and boot status/control.
// master = boot_copier; slave = the ROM/RAM/CPU-reset side of the top level.
interface boot_copier_if;
  logic        I_start;
  logic        O_rom_enable;
  logic [7:0]  O_rom_addr;
  logic [15:0] I_rom_data;
  logic        O_ram_we;
  logic [15:0] O_ram_addr;
  logic [15:0] O_ram_data;
  logic        I_ram_ready;
  logic        O_busy;
  logic        O_done;
  logic        O_cpu_reset;

  modport master (
    input  I_start, I_rom_data, I_ram_ready,
    output O_rom_enable, O_rom_addr, O_ram_we, O_ram_addr, O_ram_data,
           O_busy, O_done, O_cpu_reset
  );

  modport slave (
    output I_start, I_rom_data, I_ram_ready,
    input  O_rom_enable, O_rom_addr, O_ram_we, O_ram_addr, O_ram_data,
           O_busy, O_done, O_cpu_reset
  );
endinterface

// File: rtl/boot_copier.sv
// Boot sequencer: copies the boot ROM image into RAM one 16-bit word at a time
// (READ -> LATCH -> WRITE per word), then releases the CPU from reset.
module boot_copier #(
  parameter int          ROM_BYTES  = 256,
  parameter logic [15:0] DEST_BASE  = 16'h0000,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic          I_clk,
  input  logic          I_reset,
  boot_copier_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_WRITE, S_DONE} state_t;

  localparam logic [6:0] LAST_IDX  = 7'(ROM_BYTES / 2 - 1);
  localparam state_t     RST_STATE = AUTO_START ? S_READ : S_IDLE;

  state_t      state, state_d;
  logic [6:0]  idx, idx_d;
  logic        ram_we, ram_we_d;
  logic [15:0] ram_addr, ram_addr_d;
  logic [15:0] ram_data, ram_data_d;
  logic        busy, busy_d;
  logic        done, done_d;
  logic        cpu_reset, cpu_reset_d;

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state     <= RST_STATE;
      idx       <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= DEST_BASE;
      ram_data  <= '0;
      busy      <= AUTO_START;
      done      <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_data  <= ram_data_d;
      busy      <= busy_d;
      done      <= done_d;
      cpu_reset <= cpu_reset_d;
    end
  end

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    ram_we_d    = ram_we;
    ram_addr_d  = ram_addr;
    ram_data_d  = ram_data;
    busy_d      = busy;
    done_d      = done;
    cpu_reset_d = cpu_reset;
    case (state)
      S_IDLE, S_DONE: begin
        // cpu_reset is deliberately untouched: a restart never re-holds the CPU
        if (bus.I_start) begin
          state_d = S_READ;
          idx_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: begin
        ram_data_d = bus.I_rom_data;
        ram_addr_d = DEST_BASE + {8'h00, idx, 1'b0};
        ram_we_d   = 1'b1;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (bus.I_ram_ready) begin
          ram_we_d = 1'b0;
          if (idx == LAST_IDX) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            cpu_reset_d = 1'b0;
          end else begin
            idx_d   = idx + 7'd1;
            state_d = S_READ;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  // Reset may park the FSM in READ; gate the strobe so the ROM stays quiet while reset is held.
  assign bus.O_rom_enable = (state == S_READ) && !I_reset;
  assign bus.O_rom_addr   = {idx, 1'b0};
  assign bus.O_ram_we     = ram_we;
  assign bus.O_ram_addr   = ram_addr;
  assign bus.O_ram_data   = ram_data;
  assign bus.O_busy       = busy;
  assign bus.O_done       = done;
  assign bus.O_cpu_reset  = cpu_reset;
endmodule
